shrimp_alu_issue: RTL and testbench

Issue-side front end for the shrimp 8-bit ALU: accepts operation requests from the decode stage over a valid/ready handshake and drives the combinational ALU's operand/opcode inputs. It sequences 16-bit (wide) operations as multiple byte passes and returns a registered result with carry/overflow/error over a second valid/ready handshake. The ALU itself sits outside this block, so a bench can model it directly.

---
 rtl/shrimp_alu_issue.sv | 152 +++++++++++++++
 tb/tb_shrimp_alu_issue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shrimp_alu_issue.sv
// Issue front end for the shrimp 8-bit ALU; sequences 16-bit ops as byte passes (LO, HI, optional carry INC).
// Optional completed-response counter on op_count when SHRIMP_ALU_ISSUE_OPCNT_EN is defined.
package shrimp_alu_pkg;
  typedef enum logic [2:0] {
    ALU_XOR  = 3'd0,
    ALU_AND  = 3'd1,
    ALU_OR   = 3'd2,
    ALU_ADDU = 3'd3,
    ALU_ADDS = 3'd4,
    ALU_NEG  = 3'd5,
    ALU_CMP  = 3'd6
  } alu_opcode_e;
endpackage

module shrimp_alu_issue
  import shrimp_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  alu_opcode_e req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [7:0]  alu_operand_a,
  output logic [7:0]  alu_operand_b,
  output alu_opcode_e alu_op_code,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_err
`ifdef SHRIMP_ALU_ISSUE_OPCNT_EN
  ,
  output logic [15:0] op_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_INC, S_RESP} state_e;

  state_e      r_state, w_next;
  alu_opcode_e r_op;
  logic        r_wide;
  logic [15:0] r_a, r_b;
  logic        r_cl;
  logic        w_wide_ok;

  assign w_wide_ok = req_op inside {ALU_XOR, ALU_AND, ALU_OR, ALU_ADDU};

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    alu_operand_a = 8'h00;
    alu_operand_b = 8'h00;
    alu_op_code   = ALU_XOR;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (req_wide && !w_wide_ok) ? S_RESP : S_LO;
      end
      S_LO: begin
        alu_operand_a = r_a[7:0];
        alu_operand_b = r_b[7:0];
        alu_op_code   = r_op;
        w_next        = r_wide ? S_HI : S_RESP;
      end
      S_HI: begin
        alu_operand_a = r_a[15:8];
        alu_operand_b = r_b[15:8];
        alu_op_code   = r_op;
        w_next        = (r_op == ALU_ADDU && r_cl) ? S_INC : S_RESP;
      end
      // Propagate the low-byte carry into the already-latched high byte.
      S_INC: begin
        alu_operand_a = rsp_result[15:8];
        alu_operand_b = 8'h01;
        alu_op_code   = ALU_ADDU;
        w_next        = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= ALU_XOR;
      r_wide       <= 1'b0;
      r_a          <= 16'h0000;
      r_b          <= 16'h0000;
      r_cl         <= 1'b0;
      rsp_result   <= 16'h0000;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op         <= req_op;
            r_wide       <= req_wide;
            r_a          <= req_a;
            r_b          <= req_b;
            r_cl         <= 1'b0;
            rsp_result   <= 16'h0000;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= req_wide && !w_wide_ok;
          end
        end
        S_LO: begin
          rsp_result[7:0] <= alu_result;
          if (r_wide) begin
            r_cl <= alu_carry;
          end else begin
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
          end
        end
        // Wide logic ops report no carry; wide overflow is always zero.
        S_HI: begin
          rsp_result[15:8] <= alu_result;
          rsp_carry        <= (r_op == ALU_ADDU) && alu_carry;
        end
        S_INC: begin
          rsp_result[15:8] <= alu_result;
          rsp_carry        <= rsp_carry | alu_carry;
        end
        default: ;
      endcase
    end
  end

`ifdef SHRIMP_ALU_ISSUE_OPCNT_EN
  always_ff @(posedge clk) begin
    if (rst) op_count <= 16'h0000;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_shrimp_alu_issue.sv
// Directed bench for shrimp_alu_issue with a behavioural 8-bit ALU model.
module tb_shrimp_alu_issue;
  import shrimp_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  alu_opcode_e req_op;
  logic        req_wide;
  logic [15:0] req_a, req_b;
  logic [7:0]  alu_operand_a, alu_operand_b;
  alu_opcode_e alu_op_code;
  logic [7:0]  alu_result;
  logic        alu_carry, alu_overflow;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_overflow, rsp_err;
`ifdef SHRIMP_ALU_ISSUE_OPCNT_EN
  logic [15:0] op_count;
`endif

  int checks = 0;
  int errors = 0;
  int cnt_exp = 0;

  always #5 clk = ~clk;

  shrimp_alu_issue dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wide(req_wide),
    .req_a(req_a), .req_b(req_b),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_op_code(alu_op_code),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
`ifdef SHRIMP_ALU_ISSUE_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  logic [8:0] m_sum;
  always_comb begin
    m_sum        = 9'h000;
    alu_result   = 8'h00;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op_code)
      ALU_XOR: alu_result = alu_operand_a ^ alu_operand_b;
      ALU_AND: alu_result = alu_operand_a & alu_operand_b;
      ALU_OR:  alu_result = alu_operand_a | alu_operand_b;
      ALU_ADDU, ALU_ADDS: begin
        m_sum      = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
        alu_result = m_sum[7:0];
        alu_carry  = m_sum[8];
        if (alu_op_code == ALU_ADDS)
          alu_overflow = (alu_operand_a[7] == alu_operand_b[7]) && (m_sum[7] != alu_operand_a[7]);
      end
      ALU_NEG: begin
        alu_result = 8'h00 - alu_operand_a;
        alu_carry  = (alu_operand_a != 8'h00);
      end
      ALU_CMP: begin
        m_sum      = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
        alu_result = m_sum[7:0];
        alu_carry  = m_sum[8];
      end
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns edges from the accept edge (inclusive) until rsp_valid is seen, plus the first-pass ALU drive.
  task automatic issue(input alu_opcode_e op, input logic wide, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [7:0] lo_a, output logic [2:0] lo_op);
    @(negedge clk);
    check("req_ready_idle", 16'(req_ready), 16'h1);
    req_valid = 1'b1; req_op = op; req_wide = wide; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = ALU_NEG; req_wide = ~wide;
    lo_a  = alu_operand_a;
    lo_op = alu_op_code;
    lat   = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cnt_exp++;
    check("rsp_valid_after_take", 16'(rsp_valid), 16'h0);
    check("req_ready_after_take", 16'(req_ready), 16'h1);
`ifdef SHRIMP_ALU_ISSUE_OPCNT_EN
    check("op_count", op_count, 16'(cnt_exp));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] lo_a;
    logic [2:0] lo_op;
    int         bad;

    rst = 1'b1; req_valid = 1'b0; req_op = ALU_XOR; req_wide = 1'b0;
    req_a = 16'h0000; req_b = 16'h0000; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 16'(req_ready), 16'h1);
    check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    check("rst_rsp_result", rsp_result, 16'h0000);
    check("rst_flags", {13'h0, rsp_carry, rsp_overflow, rsp_err}, 16'h0);
    check("rst_alu_a", 16'(alu_operand_a), 16'h0);
    check("rst_alu_op", 16'(alu_op_code), 16'(ALU_XOR));
`ifdef SHRIMP_ALU_ISSUE_OPCNT_EN
    check("rst_op_count", op_count, 16'h0000);
`endif
    @(negedge clk); rst = 1'b0;
    // rsp_ready held high while idle must not matter
    @(posedge clk); #1;
    check("idle_rsp_ready_noeffect", 16'(rsp_valid), 16'h0);
    rsp_ready = 1'b0;

    issue(ALU_ADDU, 1'b0, 16'h00F0, 16'h0020, lat, lo_a, lo_op);
    check("n_addu_lat", 16'(lat), 16'd2);
    check("n_addu_lo_a", 16'(lo_a), 16'h00F0);
    check("n_addu_lo_op", 16'(lo_op), 16'(ALU_ADDU));
    check("n_addu_res", rsp_result, 16'h0010);
    check("n_addu_c_o_e", {13'h0, rsp_carry, rsp_overflow, rsp_err}, 16'b100);
    take();

    issue(ALU_ADDU, 1'b1, 16'h12FF, 16'h0101, lat, lo_a, lo_op);
    check("w_addu_lat", 16'(lat), 16'd4);
    check("w_addu_res", rsp_result, 16'h1400);
    check("w_addu_c_o_e", {13'h0, rsp_carry, rsp_overflow, rsp_err}, 16'b000);
    take();

    issue(ALU_ADDU, 1'b1, 16'hFFFF, 16'h0001, lat, lo_a, lo_op);
    check("w_addu_wrap_lat", 16'(lat), 16'd4);
    check("w_addu_wrap_res", rsp_result, 16'h0000);
    check("w_addu_wrap_c_o_e", {13'h0, rsp_carry, rsp_overflow, rsp_err}, 16'b100);
    take();

    issue(ALU_AND, 1'b1, 16'hF0F0, 16'h3C3C, lat, lo_a, lo_op);
    check("w_and_lat", 16'(lat), 16'd3);
    check("w_and_res", rsp_result, 16'h3030);
    check("w_and_c_o_e", {13'h0, rsp_carry, rsp_overflow, rsp_err}, 16'b000);
    take();

    issue(ALU_OR, 1'b1, 16'h1234, 16'h00F0, lat, lo_a, lo_op);
    check("w_or_lat", 16'(lat), 16'd3);
    check("w_or_res", rsp_result, 16'h12F4);
    take();

    issue(ALU_NEG, 1'b1, 16'h0005, 16'h0000, lat, lo_a, lo_op);
    check("w_neg_lat", 16'(lat), 16'd1);
    check("w_neg_err", 16'(rsp_err), 16'h1);
    check("w_neg_res", rsp_result, 16'h0000);
    check("w_neg_no_pass_a", 16'(lo_a), 16'h0000);
    check("w_neg_no_pass_op", 16'(lo_op), 16'(ALU_XOR));
    take();

    issue(ALU_ADDS, 1'b0, 16'h0070, 16'h0070, lat, lo_a, lo_op);
    check("n_adds_lat", 16'(lat), 16'd2);
    check("n_adds_res", rsp_result, 16'h00E0);
    check("n_adds_c_o_e", {13'h0, rsp_carry, rsp_overflow, rsp_err}, 16'b010);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== 16'h00E0 ||
          rsp_overflow !== 1'b1 || rsp_carry !== 1'b0 || rsp_err !== 1'b0)
        bad++;
    end
    check("backpressure_stable", 16'(bad), 16'd0);
    take();

    issue(ALU_CMP, 1'b0, 16'h0005, 16'h0007, lat, lo_a, lo_op);
    check("n_cmp_lat", 16'(lat), 16'd2);
    check("n_cmp_res", rsp_result, 16'h00FE);
    check("n_cmp_carry", 16'(rsp_carry), 16'h1);
    take();

    // reset while the HI pass is in flight
    @(negedge clk);
    req_valid = 1'b1; req_op = ALU_ADDU; req_wide = 1'b1; req_a = 16'h12FF; req_b = 16'h0101;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("hi_pass_op", 16'(alu_op_code), 16'(ALU_ADDU));
    check("hi_pass_a", 16'(alu_operand_a), 16'h0012);
`ifdef SHRIMP_ALU_ISSUE_OPCNT_EN
    check("op_count_inflight", op_count, 16'(cnt_exp));
`endif
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_hi_req_ready", 16'(req_ready), 16'h1);
    check("rst_hi_rsp_valid", 16'(rsp_valid), 16'h0);
    check("rst_hi_rsp_result", rsp_result, 16'h0000);
`ifdef SHRIMP_ALU_ISSUE_OPCNT_EN
    check("rst_hi_op_count", op_count, 16'h0000);
`endif
    cnt_exp = 0;
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) bad++;
    end
    check("rst_no_response", 16'(bad), 16'd0);

    issue(ALU_XOR, 1'b0, 16'h00A5, 16'h00FF, lat, lo_a, lo_op);
    check("post_rst_xor_lat", 16'(lat), 16'd2);
    check("post_rst_xor_res", rsp_result, 16'h005A);
    take();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
